// File: rtl/log2_pkg.sv
// log2_pkg: shared types and helpers for the sequential log2 unit.
//   state_t    - scan FSM state encoding
//   MODE_*     - floor / ceil select values for the mode input
//   calc_dw()  - result width: bit-index width plus one bit so ceil can return WIDTH
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FLOOR = 1'b0;
    localparam logic MODE_CEIL  = 1'b1;

    function automatic int calc_dw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/log2_seq_prio_enc.sv
// prio_enc: combinational highest-set-bit encoder for one STEP-bit chunk.
//   chunk in  STEP         bits to encode
//   pos   out clog2(STEP)  index of the highest set bit (0 when any = 0)
//   any   out 1            chunk has at least one bit set
module prio_enc #(
    parameter int STEP = 8
) (
    input  logic [STEP-1:0]                          chunk,
    output logic [((STEP > 1) ? $clog2(STEP) : 1)-1:0] pos,
    output logic                                     any
);
    localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

    // Ascending scan: the last set bit written is the highest one.
    always_comb begin
        pos = '0;
        any = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (chunk[i]) begin
                pos = PW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/log2_seq.sv
// log2_seq: sequential floor/ceil log2 over a valid/ready stream.
// The operand is scanned MSB-first, STEP bits per cycle; the first nonzero
// chunk ends the scan. One operand in flight at a time.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (num, mode sampled together)
//   num [WIDTH]         operand
//   mode                0 = floor, 1 = ceil
//   out_valid/out_ready result handshake
//   degree [DW]         log2 result (0 for a zero operand)
//   is_zero, is_pow2    operand flags
module log2_seq
    import log2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            num,
    input  logic                        mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [calc_dw(WIDTH)-1:0]   degree,
    output logic                        is_zero,
    output logic                        is_pow2
);
    localparam int NCHUNK = WIDTH / STEP;
    localparam int DW     = calc_dw(WIDTH);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = (STEP > 1) ? $clog2(STEP) : 1;

    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_num;
    logic                 r_mode;
    logic [IW-1:0]        r_idx;
    logic [DW-1:0]        r_degree;
    logic                 r_zero;
    logic                 r_pow2;

    logic [NCHUNK-1:0][STEP-1:0] w_chunks;
    logic [STEP-1:0]      w_chunk;
    logic [PW-1:0]        w_pos;
    logic                 w_any;
    logic [DW-1:0]        w_msb;
    logic [DW-1:0]        w_deg;

    assign w_chunks = r_num;
    assign w_chunk  = w_chunks[r_idx];

    prio_enc #(.STEP(STEP)) u_enc (
        .chunk (w_chunk),
        .pos   (w_pos),
        .any   (w_any)
    );

    assign w_msb = DW'(r_idx) * DW'(STEP) + DW'(w_pos);
    // Ceil adds one unless the operand is an exact power of two; for an
    // operand above 2^(WIDTH-1) this lands on WIDTH, hence the extra DW bit.
    assign w_deg = (r_mode == MODE_CEIL && !r_pow2) ? w_msb + DW'(1) : w_msb;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SCAN;
            end
            SCAN: begin
                if (w_any || r_idx == '0) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_num    <= '0;
            r_mode   <= MODE_FLOOR;
            r_idx    <= '0;
            r_degree <= '0;
            r_zero   <= 1'b0;
            r_pow2   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_num    <= num;
                        r_mode   <= mode;
                        r_idx    <= IW'(NCHUNK - 1);
                        r_zero   <= 1'b0;
                        r_degree <= '0;
                        r_pow2   <= (num != '0) && ((num & (num - 1'b1)) == '0);
                    end
                end
                SCAN: begin
                    if (w_any) begin
                        r_degree <= w_deg;
                    end else if (r_idx == '0) begin
                        r_zero   <= 1'b1;
                        r_degree <= '0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign degree  = r_degree;
    assign is_zero = r_zero;
    assign is_pow2 = r_pow2;

endmodule

// File: tb/tb_log2_seq.sv
module tb_log2_seq;
    localparam int W  = 32;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic rst, in_valid, mode, out_ready;
    logic [W-1:0] num;
    logic in_ready8, out_valid8, zero8, pow28;
    logic in_ready32, out_valid32, zero32, pow232;
    logic [DW-1:0] deg8, deg32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    log2_seq #(.WIDTH(32), .STEP(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .num(num), .mode(mode), .out_valid(out_valid8), .out_ready(out_ready),
        .degree(deg8), .is_zero(zero8), .is_pow2(pow28)
    );

    log2_seq #(.WIDTH(32), .STEP(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .num(num), .mode(mode), .out_valid(out_valid32), .out_ready(out_ready),
        .degree(deg32), .is_zero(zero32), .is_pow2(pow232)
    );

    typedef struct {
        logic [31:0] n;
        logic        m;
        int          deg;
        bit          z;
        bit          p;
        int          lat;   // latency for STEP = 8
    } vec_t;

    typedef struct {
        int deg;
        bit z;
        bit p;
        int lat;
    } res_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: log2 by powers of two, latency from the chunk position.
    function automatic res_t model(input logic [31:0] n, input logic m, input int step);
        res_t r;
        longint v;
        int fl, cl;
        v = longint'(n);
        r.z = (n == 0);
        r.p = ($countones(n) == 1);
        fl = 0;
        cl = 0;
        for (int d = 0; d <= 32; d++) begin
            if ((64'd1 << d) <= v) fl = d;
        end
        while ((64'd1 << cl) < v) cl++;
        if (r.z) begin
            r.deg = 0;
            r.lat = 1 + 32 / step;
        end else begin
            r.deg = m ? cl : fl;
            r.lat = 2 + (31 - fl) / step;
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] n, input logic m, output res_t r8, output res_t r32);
        int cyc;
        bit got8, got32;
        r8  = '{default: 0};
        r32 = '{default: 0};
        cyc = 0;
        while (!(in_ready8 && in_ready32) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_before_op", {in_ready8, in_ready32}, 2'b11);
        num = n; mode = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        num = $urandom; mode = $urandom_range(0, 1);   // captured values must not follow
        got8 = 0; got32 = 0; cyc = 1;
        while (!(got8 && got32) && cyc < 50) begin
            if (out_valid8 && !got8) begin
                got8 = 1; r8.lat = cyc; r8.deg = deg8; r8.z = zero8; r8.p = pow28;
            end
            if (out_valid32 && !got32) begin
                got32 = 1; r32.lat = cyc; r32.deg = deg32; r32.z = zero32; r32.p = pow232;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic cmp_model(input string tag, input logic [31:0] n, input logic m, input res_t a, input int step);
        res_t e;
        e = model(n, m, step);
        chk({tag, "_deg"}, a.deg, e.deg);
        chk({tag, "_zero"}, a.z, e.z);
        chk({tag, "_pow2"}, a.p, e.p);
        chk({tag, "_lat"}, a.lat, e.lat);
    endtask

    initial begin
        vec_t  vecs[9];
        res_t  r8, r32;
        logic [31:0] n;
        logic [DW-1:0] held;
        int cyc;

        vecs[0] = '{32'h8000_0000, 1'b0, 31, 1'b0, 1'b1, 2};
        vecs[1] = '{32'h0000_0001, 1'b0,  0, 1'b0, 1'b1, 5};
        vecs[2] = '{32'h0000_0001, 1'b1,  0, 1'b0, 1'b1, 5};
        vecs[3] = '{32'h0001_0001, 1'b0, 16, 1'b0, 1'b0, 3};
        vecs[4] = '{32'h0001_0001, 1'b1, 17, 1'b0, 1'b0, 3};
        vecs[5] = '{32'h8000_0001, 1'b1, 32, 1'b0, 1'b0, 2};
        vecs[6] = '{32'h0000_0000, 1'b0,  0, 1'b1, 1'b0, 5};
        vecs[7] = '{32'h0000_0000, 1'b1,  0, 1'b1, 1'b0, 5};
        vecs[8] = '{32'h0000_0100, 1'b0,  8, 1'b0, 1'b1, 4};

        rst = 1'b1; in_valid = 1'b0; num = '0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_degree", deg8, 0);
        chk("rst_flags", {zero8, pow28}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].n, vecs[i].m, r8, r32);
            chk($sformatf("vec%0d_deg", i), r8.deg, vecs[i].deg);
            chk($sformatf("vec%0d_zero", i), r8.z, vecs[i].z);
            chk($sformatf("vec%0d_pow2", i), r8.p, vecs[i].p);
            chk($sformatf("vec%0d_lat", i), r8.lat, vecs[i].lat);
            cmp_model($sformatf("vec%0d_s32", i), vecs[i].n, vecs[i].m, r32, 32);
        end

        // Backpressure: result holds while out_ready is low
        out_ready = 1'b0;
        num = 32'h0000_1000; mode = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_out_valid", out_valid8, 1);
        held = deg8;
        chk("bp_degree", held, 12);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid8, 1);
            chk("bp_hold_degree", deg8, 12);
            chk("bp_hold_flags", {zero8, pow28}, 2'b01);
            chk("bp_in_ready", in_ready8, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready8, 1);
        chk("bp_release_out_valid", out_valid8, 0);

        // Reset mid-scan
        num = 32'h0000_0001; mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready8, 1);
        chk("midrst_out_valid", out_valid8, 0);
        chk("midrst_degree", deg8, 0);
        run_op(32'h0000_0100, 1'b0, r8, r32);
        chk("after_rst_deg", r8.deg, 8);
        chk("after_rst_lat", r8.lat, 4);

        // Reset and input handshake together: nothing captured
        rst = 1'b1; in_valid = 1'b1; num = 32'h0000_0001;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_vs_valid_in_ready", in_ready8, 1);
        chk("rst_vs_valid_out_valid", out_valid8, 0);

        // Sweep 2^k and 2^k+1
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 4; j++) begin
                n = (32'd1 << k) + ((j >= 2) ? 32'd1 : 32'd0);
                run_op(n, j[0], r8, r32);
                cmp_model($sformatf("sw_k%0d_j%0d_s8", k, j), n, j[0], r8, 8);
                cmp_model($sformatf("sw_k%0d_j%0d_s32", k, j), n, j[0], r32, 32);
            end
        end

        // Random operands of varied magnitude
        for (int t = 0; t < 60; t++) begin
            logic m;
            n = $urandom >> $urandom_range(0, 31);
            m = $urandom_range(0, 1);
            run_op(n, m, r8, r32);
            cmp_model($sformatf("rnd%0d_s8", t), n, m, r8, 8);
            cmp_model($sformatf("rnd%0d_s32", t), n, m, r32, 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
